// File: rtl/operand_packer_if.sv
// Bundle of the operand/result stream and BRAM-side handshakes of operand_packer.
// The slave modport is the packer's own view; master is the surrounding system.
interface operand_packer_if #(
    parameter int WORD_LEN = 512,
    parameter int IN_W     = 32
);
    logic [IN_W-1:0]     s_data;
    logic                s_valid;
    logic                s_ready;
    logic [WORD_LEN-1:0] bram_din1;
    logic [WORD_LEN-1:0] bram_din2;
    logic                bram_din_valid;
    logic                bram_din_ack;
    logic [WORD_LEN-1:0] bram_dout1;
    logic                bram_dout1_valid;
    logic                bram_dout_read;
    logic [IN_W-1:0]     m_data;
    logic                m_valid;
    logic                m_ready;

    modport slave (
        input  s_data, s_valid, bram_din_ack, bram_dout1, bram_dout1_valid, m_ready,
        output s_ready, bram_din1, bram_din2, bram_din_valid, bram_dout_read, m_data, m_valid
    );

    modport master (
        output s_data, s_valid, bram_din_ack, bram_dout1, bram_dout1_valid, m_ready,
        input  s_ready, bram_din1, bram_din2, bram_din_valid, bram_dout_read, m_data, m_valid
    );
endinterface

// File: rtl/operand_packer.sv
// operand_packer: gathers IN_W-bit stream words into two WORD_LEN-bit operands
// (A then B, least significant word first) for a multiplier wrapper, and
// serialises the WORD_LEN-bit result back onto an IN_W-bit stream.
// Packer and unpacker are independent state machines running concurrently.
module operand_packer #(
    parameter int WORD_LEN = 512,
    parameter int IN_W     = 32
) (
    input  logic            clk,
    input  logic            resetn,
    operand_packer_if.slave bus
);
    localparam int N     = WORD_LEN / IN_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {LOAD_A, LOAD_B, HOLD} pk_state_t;
    typedef enum logic       {IDLE, SEND}           up_state_t;

    pk_state_t           r_pk_state, w_pk_next;
    logic [CNT_W-1:0]    r_pk_cnt;
    logic [WORD_LEN-1:0] r_din1, r_din2;
    logic                w_s_ready, w_din_valid, w_s_fire, w_pk_last;

    up_state_t           r_up_state, w_up_next;
    logic [CNT_W-1:0]    r_up_cnt;
    logic [WORD_LEN-1:0] r_shift;
    logic                w_m_valid, w_dout_read, w_capture, w_m_fire, w_up_last;

    assign w_s_fire  = bus.s_valid & w_s_ready;
    assign w_pk_last = (r_pk_cnt == CNT_W'(N - 1));
    assign w_capture = (r_up_state == IDLE) & bus.bram_dout1_valid;
    assign w_m_fire  = w_m_valid & bus.m_ready;
    assign w_up_last = (r_up_cnt == CNT_W'(N - 1));

    // Packer state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_pk_state <= LOAD_A;
        else         r_pk_state <= w_pk_next;
    end

    // Packer next state and state-decoded outputs; s_ready is held low while in reset.
    always_comb begin
        w_pk_next   = r_pk_state;
        w_s_ready   = 1'b0;
        w_din_valid = 1'b0;
        case (r_pk_state)
            LOAD_A: begin
                w_s_ready = resetn;
                if (w_s_fire && w_pk_last) w_pk_next = LOAD_B;
            end
            LOAD_B: begin
                w_s_ready = resetn;
                if (w_s_fire && w_pk_last) w_pk_next = HOLD;
            end
            HOLD: begin
                w_din_valid = 1'b1;
                if (bus.bram_din_ack) w_pk_next = LOAD_A;
            end
            default: w_pk_next = LOAD_A;
        endcase
    end

    // Word counter and operand registers; operands keep old contents until overwritten.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pk_cnt <= '0;
            r_din1   <= '0;
            r_din2   <= '0;
        end else if (w_s_fire) begin
            if (r_pk_state == LOAD_A) r_din1[int'(r_pk_cnt) * IN_W +: IN_W] <= bus.s_data;
            else                      r_din2[int'(r_pk_cnt) * IN_W +: IN_W] <= bus.s_data;
            r_pk_cnt <= w_pk_last ? '0 : r_pk_cnt + 1'b1;
        end
    end

    // Unpacker state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_up_state <= IDLE;
        else         r_up_state <= w_up_next;
    end

    // Unpacker next state and outputs; the read pulse coincides with the capture cycle.
    always_comb begin
        w_up_next   = r_up_state;
        w_m_valid   = 1'b0;
        w_dout_read = 1'b0;
        case (r_up_state)
            IDLE: begin
                w_dout_read = resetn & bus.bram_dout1_valid;
                if (bus.bram_dout1_valid) w_up_next = SEND;
            end
            SEND: begin
                w_m_valid = 1'b1;
                if (bus.m_ready && w_up_last) w_up_next = IDLE;
            end
            default: w_up_next = IDLE;
        endcase
    end

    // Result shift register; shifting in zeros leaves it cleared after the last word.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_shift  <= '0;
            r_up_cnt <= '0;
        end else if (w_capture) begin
            r_shift  <= bus.bram_dout1;
            r_up_cnt <= '0;
        end else if (w_m_fire) begin
            r_shift  <= r_shift >> IN_W;
            r_up_cnt <= w_up_last ? '0 : r_up_cnt + 1'b1;
        end
    end

    assign bus.s_ready        = w_s_ready;
    assign bus.bram_din1      = r_din1;
    assign bus.bram_din2      = r_din2;
    assign bus.bram_din_valid = w_din_valid;
    assign bus.bram_dout_read = w_dout_read;
    assign bus.m_valid        = w_m_valid;
    assign bus.m_data         = r_shift[IN_W-1:0];
endmodule

// File: tb/tb_operand_packer.sv
// Testbench for operand_packer: random and directed streams checked against
// a word-position model of the two operands and of the serialised result.
module tb_operand_packer;
    localparam int WL = 512;
    localparam int IW = 32;
    localparam int N  = WL / IW;

    logic clk;
    logic resetn;
    int   n_checks;
    int   n_fail;

    // Reference model: position of the next word in the 2N-word load, and operand images.
    int          p;
    logic [WL-1:0] exp1, exp2;

    operand_packer_if #(.WORD_LEN(WL), .IN_W(IW)) bus ();

    operand_packer #(.WORD_LEN(WL), .IN_W(IW)) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WL-1:0] rand_wide();
        logic [WL-1:0] r;
        r = '0;
        for (int i = 0; i < WL / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [IW-1:0] word_of(input logic [WL-1:0] v, input int k);
        logic [WL-1:0] s;
        s = v >> (k * IW);
        return s[IW-1:0];
    endfunction

    task automatic model_accept(input logic [IW-1:0] w);
        if (p < N) exp1[p*IW +: IW] = w;
        else       exp2[(p-N)*IW +: IW] = w;
        p++;
    endtask

    task automatic check_all_zero(input string tag);
        n_checks++;
        if (bus.s_ready !== 1'b0 || bus.bram_din_valid !== 1'b0 || bus.bram_dout_read !== 1'b0 ||
            bus.m_valid !== 1'b0 || bus.m_data !== '0) begin
            n_fail++;
            $display("FAIL %s_ctrl: got s_ready=%b din_valid=%b read=%b m_valid=%b m_data=%h, expected all 0",
                     tag, bus.s_ready, bus.bram_din_valid, bus.bram_dout_read, bus.m_valid, bus.m_data);
        end
        n_checks++;
        if (bus.bram_din1 !== '0 || bus.bram_din2 !== '0) begin
            n_fail++;
            $display("FAIL %s_din: got din1=%h din2=%h, expected 0", tag, bus.bram_din1, bus.bram_din2);
        end
    endtask

    // mode 0: words 1,2,3,... continuous; 1: random continuous; 2: random with gaps and stray acks
    task automatic load(input int n, input int mode);
        int sent;
        int cyc;
        logic [IW-1:0] w;
        sent = 0;
        cyc  = 0;
        while (sent < n && cyc < 4000) begin
            @(negedge clk);
            n_checks++;
            if (bus.s_ready !== 1'b1 || bus.bram_din_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL load_ready: got s_ready=%b din_valid=%b, expected 1/0 at word %0d",
                         bus.s_ready, bus.bram_din_valid, p);
            end
            w = (mode == 0) ? IW'(sent + 1) : IW'($urandom);
            bus.s_data       = w;
            bus.s_valid      = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.bram_din_ack = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk);
            if (bus.s_valid) begin
                model_accept(w);
                sent++;
            end
            cyc++;
        end
        @(negedge clk);
        bus.s_valid      = 1'b0;
        bus.bram_din_ack = 1'b0;
        n_checks++;
        if (sent != n) begin
            n_fail++;
            $display("FAIL load_timeout: sent %0d words, expected %0d", sent, n);
        end
        n_checks++;
        if (bus.bram_din_valid !== (p == 2*N) || bus.s_ready !== (p != 2*N)) begin
            n_fail++;
            $display("FAIL load_end_state: got din_valid=%b s_ready=%b, expected %b/%b",
                     bus.bram_din_valid, bus.s_ready, (p == 2*N), (p != 2*N));
        end
        n_checks++;
        if (bus.bram_din1 !== exp1) begin
            n_fail++;
            $display("FAIL load_din1: got %h expected %h", bus.bram_din1, exp1);
        end
        n_checks++;
        if (bus.bram_din2 !== exp2) begin
            n_fail++;
            $display("FAIL load_din2: got %h expected %h", bus.bram_din2, exp2);
        end
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        bus.bram_din_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.bram_din_ack = 1'b0;
        p = 0;
        n_checks++;
        if (bus.s_ready !== 1'b1 || bus.bram_din_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_release: got s_ready=%b din_valid=%b, expected 1/0",
                     bus.s_ready, bus.bram_din_valid);
        end
    endtask

    task automatic recv(input logic [WL-1:0] val, input bit stall);
        int k;
        int cyc;
        @(negedge clk);
        bus.bram_dout1       = val;
        bus.bram_dout1_valid = 1'b1;
        #1;
        n_checks++;
        if (bus.bram_dout_read !== 1'b1 || bus.m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL recv_capture: got read=%b m_valid=%b, expected 1/0", bus.bram_dout_read, bus.m_valid);
        end
        @(posedge clk);
        @(negedge clk);
        // keep a different result offered during SEND: it must be ignored
        bus.bram_dout1 = ~val;
        k   = 0;
        cyc = 0;
        while (k < N && cyc < 2000) begin
            #1;
            n_checks++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== word_of(val, k)) begin
                n_fail++;
                $display("FAIL recv_word: got m_valid=%b m_data=%h, expected 1/%h at word %0d",
                         bus.m_valid, bus.m_data, word_of(val, k), k);
            end
            n_checks++;
            if (bus.bram_dout_read !== 1'b0) begin
                n_fail++;
                $display("FAIL recv_read_in_send: got read=%b expected 0", bus.bram_dout_read);
            end
            bus.m_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.m_ready && k == N-1) bus.bram_dout1_valid = 1'b0;
            @(posedge clk);
            if (bus.m_ready) k++;
            cyc++;
            @(negedge clk);
        end
        bus.m_ready          = 1'b0;
        bus.bram_dout1_valid = 1'b0;
        #1;
        n_checks++;
        if (k != N || bus.m_valid !== 1'b0 || bus.bram_dout_read !== 1'b0) begin
            n_fail++;
            $display("FAIL recv_end: got %0d words m_valid=%b read=%b, expected %0d/0/0",
                     k, bus.m_valid, bus.bram_dout_read, N);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        resetn = 1'b1;
        p = 0; exp1 = '0; exp2 = '0;
        @(negedge clk);
        n_checks++;
        if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got s_ready=%b m_valid=%b, expected 1/0", bus.s_ready, bus.m_valid);
        end
    endtask

    task automatic test_load_seq();
        logic [WL-1:0] e1;
        logic [WL-1:0] e2;
        load(2*N, 0);
        for (int k = 0; k < N; k++) begin
            e1[k*IW +: IW] = IW'(k + 1);
            e2[k*IW +: IW] = IW'(k + 1 + N);
        end
        n_checks++;
        if (bus.bram_din1 !== e1 || bus.bram_din2 !== e2) begin
            n_fail++;
            $display("FAIL seq_operands: got din1=%h din2=%h", bus.bram_din1, bus.bram_din2);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            bus.s_valid = 1'b1;
            bus.s_data  = IW'($urandom);
            n_checks++;
            if (bus.s_ready !== 1'b0 || bus.bram_din_valid !== 1'b1 ||
                bus.bram_din1 !== exp1 || bus.bram_din2 !== exp2) begin
                n_fail++;
                $display("FAIL hold_stable: cycle %0d s_ready=%b din_valid=%b din1_ok=%b din2_ok=%b, expected 0/1/1/1",
                         i, bus.s_ready, bus.bram_din_valid, bus.bram_din1 === exp1, bus.bram_din2 === exp2);
            end
            @(posedge clk);
        end
        bus.s_valid = 1'b0;
        ack_pulse();
        load(1, 1);
        load(2*N - 1, 1);
        ack_pulse();
    endtask

    task automatic test_unpack_seq();
        logic [WL-1:0] v;
        for (int k = 0; k < N; k++) v[k*IW +: IW] = IW'(k);
        recv(v, 1'b0);
    endtask

    task automatic test_stall();
        recv(rand_wide(), 1'b1);
    endtask

    task automatic test_reset_mid();
        logic [WL-1:0] v;
        logic [IW-1:0] w;
        v = rand_wide();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            w = IW'($urandom);
            bus.s_data           = w;
            bus.s_valid          = (i < 7);
            bus.bram_dout1       = v;
            bus.bram_dout1_valid = (i == 1);
            bus.m_ready          = (i >= 2);
            #1;
            if (i >= 2) begin
                n_checks++;
                if (bus.m_valid !== 1'b1 || bus.m_data !== word_of(v, i - 2)) begin
                    n_fail++;
                    $display("FAIL mid_word: got m_valid=%b m_data=%h, expected 1/%h",
                             bus.m_valid, bus.m_data, word_of(v, i - 2));
                end
            end
            if (i < 7) begin
                @(posedge clk);
                model_accept(w);
            end
        end
        n_checks++;
        if (bus.bram_din1[7*IW-1:0] !== exp1[7*IW-1:0]) begin
            n_fail++;
            $display("FAIL mid_partial_a: got %h expected %h", bus.bram_din1[7*IW-1:0], exp1[7*IW-1:0]);
        end
        resetn = 1'b0;
        #1;
        check_all_zero("mid_reset");
        bus.s_valid = 1'b0; bus.m_ready = 1'b0; bus.bram_dout1_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        p = 0; exp1 = '0; exp2 = '0;
        #1;
        n_checks++;
        if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_release: got s_ready=%b m_valid=%b, expected 1/0", bus.s_ready, bus.m_valid);
        end
        load(2*N, 1);
        ack_pulse();
        recv(rand_wide(), 1'b0);
    endtask

    task automatic test_concurrent();
        logic [WL-1:0] v;
        v = rand_wide();
        fork
            load(2*N, 2);
            recv(v, 1'b1);
        join
        ack_pulse();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        p = 0; exp1 = '0; exp2 = '0;
        resetn               = 1'b0;
        bus.s_data           = '0;
        bus.s_valid          = 1'b0;
        bus.bram_din_ack     = 1'b0;
        bus.bram_dout1       = '0;
        bus.bram_dout1_valid = 1'b0;
        bus.m_ready          = 1'b0;
        test_reset();
        test_load_seq();
        test_hold();
        test_unpack_seq();
        test_stall();
        test_reset_mid();
        test_concurrent();
        test_concurrent();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/operand_packer.md
OPERAND_PACKER -- requirements
Module: operand_packer

Interface
REQ-001 Parameter WORD_LEN, default 512, operand/result width in bits.
REQ-002 Parameter IN_W, default 32, stream word width; WORD_LEN SHALL be an integer multiple of IN_W (N = WORD_LEN/IN_W, 16 at defaults).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 s_data  input  IN_W  upstream operand word.
REQ-006 s_valid  input  1  s_data valid.
REQ-007 s_ready  output  1  packer accepts s_data this cycle.
REQ-008 bram_din1  output  WORD_LEN  packed operand A to multiplier wrapper.
REQ-009 bram_din2  output  WORD_LEN  packed operand B to multiplier wrapper.
REQ-010 bram_din_valid  output  1  both operands complete and stable.
REQ-011 bram_din_ack  input  1  one-cycle pulse from consumer: operands taken.
REQ-012 bram_dout1  input  WORD_LEN  result from multiplier wrapper.
REQ-013 bram_dout1_valid  input  1  bram_dout1 valid.
REQ-014 bram_dout_read  output  1  one-cycle pulse: result captured.
REQ-015 m_data  output  IN_W  downstream result word.
REQ-016 m_valid  output  1  m_data valid.
REQ-017 m_ready  input  1  downstream accepts m_data.

Function
REQ-018 Packer and unpacker SHALL be independent FSMs operating concurrently.
REQ-019 Packer states: LOAD_A, LOAD_B, HOLD; s_ready SHALL be 1 in LOAD_A/LOAD_B, 0 in HOLD (decoded from state only).
REQ-020 Transfer on s_valid & s_ready; k-th accepted word (k = 0..N-1) per operand SHALL be written to bits [k*IN_W +: IN_W] (LSW first).
REQ-021 Word counter log2(N) bits; after word N-1 of A -> LOAD_B, counter wraps to 0; after word N-1 of B -> HOLD.
REQ-022 In HOLD, bram_din_valid SHALL be 1 and bram_din1/bram_din2 SHALL not change.
REQ-023 bram_din_ack in HOLD -> LOAD_A next cycle, bram_din_valid 0, s_ready 1; registers retain old values until overwritten.
REQ-024 bram_din_ack outside HOLD SHALL be ignored.
REQ-025 Unpacker states: IDLE, SEND.
REQ-026 In IDLE with bram_dout1_valid=1: capture bram_dout1 into shift register, pulse bram_dout_read for exactly that cycle, go to SEND.
REQ-027 In SEND: m_valid=1, m_data = current low IN_W bits; on m_ready shift right by IN_W, increment counter.
REQ-028 m_data/m_valid SHALL hold stable while m_valid & !m_ready.
REQ-029 After N-th accepted word -> IDLE; m_valid 0 next cycle; earliest new capture one cycle after returning to IDLE.
REQ-030 bram_dout1_valid in SEND SHALL be ignored; bram_dout_read never asserted in SEND.
REQ-031 Latency: bram_din_valid rises cycle after word 2N-1 accepted; first m_valid cycle after capture.

Reset
REQ-032 resetn=0 SHALL immediately force: packer LOAD_A, unpacker IDLE, counters 0, bram_din1/bram_din2/shift register 0, bram_din_valid 0, bram_dout_read 0, m_valid 0, m_data 0, s_ready 0 while reset asserted.
REQ-033 Reset mid-operation SHALL discard partial operands/results; after release s_ready=1 and first accepted word is word 0 of A.

Verification
REQ-034 Stream words 0x1..0x20 continuous -> bram_din1 = {0x10,...,0x1} (0x1 at [31:0]), bram_din2 = {0x20,...,0x11}, bram_din_valid 1 cycle after 32nd word, s_ready 0.
REQ-035 Hold ack low 50 cycles with s_valid=1 -> no words accepted, outputs stable; ack pulse -> s_ready 1 next cycle, next word lands in bram_din1[31:0].
REQ-036 bram_dout1 = 512'h0F...0E...01 pattern (word k = k) with m_ready=1 -> one bram_dout_read pulse, m_data 0,1,...,15 on 16 consecutive cycles.
REQ-037 m_ready toggling 1/0 -> each word held while stalled, no word lost or duplicated, total 16 transfers.
REQ-038 resetn pulsed low after 7 words of A and during result word 5 -> all outputs 0; new 32-word load and new result stream start from word 0.
REQ-039 Concurrent load and result streaming -> both complete with correct data, no interference.
